// File: rtl/i2cs_reg_arbiter_pkg.sv
// Shared types and constants for the I2C-slave register-port arbiter.
// The state enum and the port numbering are used by both the RTL and the bench.
package i2cs_arb_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   localparam logic PORT_APB = 1'b0;
   localparam logic PORT_I2C = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/i2cs_reg_arbiter_if.sv
// Bundles both requester handshakes and the register-file port of the arbiter.
// The arbiter connects through the slave modport; the requesters and register model use master.
interface i2cs_reg_arbiter_if;
   import i2cs_arb_pkg::*;

   logic              apb_req_i;
   logic              apb_we_i;
   logic [ADDR_W-1:0] apb_addr_i;
   logic [DATA_W-1:0] apb_wdata_i;
   logic              apb_ack_o;
   logic [DATA_W-1:0] apb_rdata_o;

   logic              i2c_req_i;
   logic              i2c_we_i;
   logic [ADDR_W-1:0] i2c_addr_i;
   logic [DATA_W-1:0] i2c_wdata_i;
   logic              i2c_ack_o;
   logic [DATA_W-1:0] i2c_rdata_o;

   logic [ADDR_W-1:0] reg_addr_o;
   logic [DATA_W-1:0] reg_wdata_o;
   logic              reg_we_o;
   logic              reg_re_o;
   logic [DATA_W-1:0] reg_rdata_i;
   logic              reg_owner_o;
   logic              busy_o;

   modport slave (
      input  apb_req_i, apb_we_i, apb_addr_i, apb_wdata_i,
      input  i2c_req_i, i2c_we_i, i2c_addr_i, i2c_wdata_i,
      input  reg_rdata_i,
      output apb_ack_o, apb_rdata_o, i2c_ack_o, i2c_rdata_o,
      output reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
      output reg_owner_o, busy_o
   );

   modport master (
      output apb_req_i, apb_we_i, apb_addr_i, apb_wdata_i,
      output i2c_req_i, i2c_we_i, i2c_addr_i, i2c_wdata_i,
      output reg_rdata_i,
      input  apb_ack_o, apb_rdata_o, i2c_ack_o, i2c_rdata_o,
      input  reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
      input  reg_owner_o, busy_o
   );

endinterface

// File: rtl/i2cs_reg_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone eligible request wins, a tie goes to the
// port that was not granted last. Purely combinational.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic [1:0] mask_i,
   input  logic       last_grant_i,
   output logic       gnt_o,
   output logic       valid_o
);

   logic [1:0] eligible;

   always_comb begin
      eligible = req_i & ~mask_i;
      valid_o  = |eligible;
      gnt_o    = 1'b0;
      unique case (eligible)
         2'b01:   gnt_o = 1'b0;
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_grant_i;
         default: gnt_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/i2cs_reg_arbiter.sv
// Shares one register-file port between the APB side (port 0) and the I2C engine
// (port 1): round-robin grant, one strobe cycle, one ack cycle per transaction.
module i2cs_reg_arbiter
   import i2cs_arb_pkg::*;
(
   input  logic              apb_pclk_i,
   input  logic              apb_presetn_i,
   i2cs_reg_arbiter_if.slave bus
);

   arb_state_e        state_q;
   logic              lastGrant_q;
   logic              owner_q;
   logic              we_q;
   logic              regWe_q;
   logic              regRe_q;
   logic              apbAck_q;
   logic              i2cAck_q;
   logic              busy_q;
   logic [ADDR_W-1:0] regAddr_q;
   logic [DATA_W-1:0] regWdata_q;
   logic [DATA_W-1:0] apbRdata_q;
   logic [DATA_W-1:0] i2cRdata_q;

   logic [1:0]        reqMask_d;
   logic              gnt_d;
   logic              gntValid_d;
   logic              selWe_d;
   logic [ADDR_W-1:0] selAddr_d;
   logic [DATA_W-1:0] selWdata_d;

   // The port being acked still holds its req this cycle, so hide it from the picker.
   always_comb begin
      reqMask_d = 2'b00;
      if (state_q == RESP) begin
         reqMask_d[owner_q] = 1'b1;
      end
   end

   rr_arb2 uArb (
      .req_i        ({bus.i2c_req_i, bus.apb_req_i}),
      .mask_i       (reqMask_d),
      .last_grant_i (lastGrant_q),
      .gnt_o        (gnt_d),
      .valid_o      (gntValid_d)
   );

   always_comb begin
      if (gnt_d == PORT_I2C) begin
         selWe_d    = bus.i2c_we_i;
         selAddr_d  = bus.i2c_addr_i;
         selWdata_d = bus.i2c_wdata_i;
      end else begin
         selWe_d    = bus.apb_we_i;
         selAddr_d  = bus.apb_addr_i;
         selWdata_d = bus.apb_wdata_i;
      end
   end

   // RESP can grant directly into ACCESS, so alternating ports need no IDLE gap.
   always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         regWe_q     <= 1'b0;
         regRe_q     <= 1'b0;
         apbAck_q    <= 1'b0;
         i2cAck_q    <= 1'b0;
         busy_q      <= 1'b0;
         regAddr_q   <= '0;
         regWdata_q  <= '0;
         apbRdata_q  <= '0;
         i2cRdata_q  <= '0;
      end else begin
         regWe_q  <= 1'b0;
         regRe_q  <= 1'b0;
         apbAck_q <= 1'b0;
         i2cAck_q <= 1'b0;
         unique case (state_q)
            IDLE, RESP: begin
               if (gntValid_d) begin
                  owner_q     <= gnt_d;
                  lastGrant_q <= gnt_d;
                  we_q        <= selWe_d;
                  regAddr_q   <= selAddr_d;
                  regWdata_q  <= selWdata_d;
                  regWe_q     <= selWe_d;
                  regRe_q     <= ~selWe_d;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  if (owner_q == PORT_I2C) begin
                     i2cRdata_q <= bus.reg_rdata_i;
                  end else begin
                     apbRdata_q <= bus.reg_rdata_i;
                  end
               end
               if (owner_q == PORT_I2C) begin
                  i2cAck_q <= 1'b1;
               end else begin
                  apbAck_q <= 1'b1;
               end
               state_q <= RESP;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.reg_addr_o  = regAddr_q;
   assign bus.reg_wdata_o = regWdata_q;
   assign bus.reg_we_o    = regWe_q;
   assign bus.reg_re_o    = regRe_q;
   assign bus.reg_owner_o = owner_q;
   assign bus.busy_o      = busy_q;
   assign bus.apb_ack_o   = apbAck_q;
   assign bus.apb_rdata_o = apbRdata_q;
   assign bus.i2c_ack_o   = i2cAck_q;
   assign bus.i2c_rdata_o = i2cRdata_q;

endmodule

// File: tb/tb_i2cs_reg_arbiter.sv
// Bench for i2cs_reg_arbiter: two random requesters feed a scoreboard, and a
// negedge monitor checks grants, strobes, acks and read data against a reference model.
module tb_i2cs_reg_arbiter;
   import i2cs_arb_pkg::*;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } txn_t;

   logic clk;
   logic presetn;
   int   checks;
   int   failures;
   bit   monEn;

   txn_t portQ0[$];
   txn_t portQ1[$];

   logic [DATA_W-1:0] rdModel[2];
   logic [1:0]        prevReq;
   logic [1:0]        prevAck;
   logic              prevStrobe;
   logic              prevOwner;
   logic              lastGrantModel;

   i2cs_reg_arbiter_if bus ();

   i2cs_reg_arbiter dut (
      .apb_pclk_i    (clk),
      .apb_presetn_i (presetn),
      .bus           (bus)
   );

   // The register file answers with a fixed function of the address.
   function automatic logic [DATA_W-1:0] regModel(input logic [ADDR_W-1:0] a);
      return {a ^ 12'hA5C, 8'h3C, a};
   endfunction

   assign bus.reg_rdata_i = regModel(bus.reg_addr_o);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issues one transaction on a port and holds req until the ack arrives.
   task automatic issueOne(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
      txn_t t;
      int   waitCnt;
      logic gotAck;
      t.we = we;
      t.addr = addr;
      t.wdata = wdata;
      if (p == 0) begin
         portQ0.push_back(t);
         bus.apb_we_i = we;
         bus.apb_addr_i = addr;
         bus.apb_wdata_i = wdata;
         bus.apb_req_i = 1'b1;
      end else begin
         portQ1.push_back(t);
         bus.i2c_we_i = we;
         bus.i2c_addr_i = addr;
         bus.i2c_wdata_i = wdata;
         bus.i2c_req_i = 1'b1;
      end
      waitCnt = 0;
      gotAck = 1'b0;
      while (!gotAck && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
         gotAck = (p == 0) ? bus.apb_ack_o : bus.i2c_ack_o;
      end
      if (!gotAck) begin
         checks++;
         failures++;
         $display("[TB] FAIL ack_timeout port=%0d actual=none expected=ack", p);
      end
      if (p == 0) bus.apb_req_i = 1'b0;
      else bus.i2c_req_i = 1'b0;
   endtask

   task automatic applyStimulus(input int p, input int nTrans, input int maxGap);
      int gap;
      for (int i = 0; i < nTrans; i++) begin
         gap = $urandom_range(maxGap, 0);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         issueOne(p, 1'($urandom_range(1, 0)), 12'($urandom), $urandom);
      end
   endtask

   // Reference model: a free arbiter grants the cycle after any unmasked request,
   // ties alternate, and each strobe is followed by exactly one ack to its owner.
   always @(negedge clk) begin
      logic [1:0] req;
      logic [1:0] ack;
      logic [1:0] elig;
      logic [1:0] expAck;
      logic       strobe;
      logic       expStrobe;
      logic       expOwner;
      txn_t       t;
      if (monEn) begin
         req = {bus.i2c_req_i, bus.apb_req_i};
         ack = {bus.i2c_ack_o, bus.apb_ack_o};
         strobe = bus.reg_we_o | bus.reg_re_o;
         elig = prevReq & ~prevAck;
         expStrobe = !prevStrobe && (elig != 2'b00);
         expOwner = 1'b0;
         checkOutput("strobe", 32'(strobe), 32'(expStrobe));
         if (strobe && expStrobe) begin
            expOwner = (elig == 2'b11) ? ~lastGrantModel : elig[1];
            checkOutput("owner", 32'(bus.reg_owner_o), 32'(expOwner));
            lastGrantModel = expOwner;
            if ((expOwner ? portQ1.size() : portQ0.size()) == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL scoreboard_empty port=%0d actual=strobe expected=none", expOwner);
            end else begin
               t = expOwner ? portQ1[0] : portQ0[0];
               checkOutput("reg_we", 32'(bus.reg_we_o), 32'(t.we));
               checkOutput("reg_re", 32'(bus.reg_re_o), 32'(!t.we));
               checkOutput("reg_addr", 32'(bus.reg_addr_o), 32'(t.addr));
               checkOutput("reg_wdata", bus.reg_wdata_o, t.wdata);
            end
         end
         expAck = prevStrobe ? (prevOwner ? 2'b10 : 2'b01) : 2'b00;
         checkOutput("ack", 32'(ack), 32'(expAck));
         if (ack[0] && expAck[0] && portQ0.size() > 0) begin
            t = portQ0.pop_front();
            if (!t.we) rdModel[0] = regModel(t.addr);
         end
         if (ack[1] && expAck[1] && portQ1.size() > 0) begin
            t = portQ1.pop_front();
            if (!t.we) rdModel[1] = regModel(t.addr);
         end
         checkOutput("apb_rdata", bus.apb_rdata_o, rdModel[0]);
         checkOutput("i2c_rdata", bus.i2c_rdata_o, rdModel[1]);
         checkOutput("busy", 32'(bus.busy_o), 32'(strobe || prevStrobe));
         prevReq = req;
         prevAck = ack;
         prevStrobe = strobe;
         if (strobe) prevOwner = expStrobe ? expOwner : bus.reg_owner_o;
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_apb_ack"}, 32'(bus.apb_ack_o), 32'd0);
      checkOutput({tag, "_i2c_ack"}, 32'(bus.i2c_ack_o), 32'd0);
      checkOutput({tag, "_apb_rdata"}, bus.apb_rdata_o, 32'd0);
      checkOutput({tag, "_i2c_rdata"}, bus.i2c_rdata_o, 32'd0);
      checkOutput({tag, "_reg_addr"}, 32'(bus.reg_addr_o), 32'd0);
      checkOutput({tag, "_reg_wdata"}, bus.reg_wdata_o, 32'd0);
      checkOutput({tag, "_reg_we"}, 32'(bus.reg_we_o), 32'd0);
      checkOutput({tag, "_reg_re"}, 32'(bus.reg_re_o), 32'd0);
      checkOutput({tag, "_owner"}, 32'(bus.reg_owner_o), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      monEn = 1'b0;
      presetn = 1'b0;
      bus.apb_req_i = 1'b0;
      bus.apb_we_i = 1'b0;
      bus.apb_addr_i = '0;
      bus.apb_wdata_i = '0;
      bus.i2c_req_i = 1'b0;
      bus.i2c_we_i = 1'b0;
      bus.i2c_addr_i = '0;
      bus.i2c_wdata_i = '0;

      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      presetn = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         checkOutput("idle_strobe", 32'(bus.reg_we_o | bus.reg_re_o), 32'd0);
         checkOutput("idle_busy", 32'(bus.busy_o), 32'd0);
      end

      // Reset arriving mid-ACCESS must drop the transaction with no ack.
      bus.apb_we_i = 1'b0;
      bus.apb_addr_i = 12'h010;
      bus.apb_req_i = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_pre_re", 32'(bus.reg_re_o), 32'd1);
      presetn = 1'b0;
      #1;
      checkAllZero("midrst");
      bus.apb_req_i = 1'b0;
      @(posedge clk);
      #1;
      presetn = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("midrst_no_ack", 32'(bus.apb_ack_o), 32'd0);
      end

      prevReq = 2'b00;
      prevAck = 2'b00;
      prevStrobe = 1'b0;
      prevOwner = 1'b0;
      lastGrantModel = 1'b1;
      rdModel[0] = '0;
      rdModel[1] = '0;
      monEn = 1'b1;

      fork
         issueOne(0, 1'b0, 12'($urandom), $urandom);
         issueOne(1, 1'b0, 12'($urandom), $urandom);
      join
      issueOne(0, 1'b1, 12'h004, 32'hDEADBEEF);
      issueOne(1, 1'b0, 12'h010, 32'h0);
      fork
         applyStimulus(0, 10, 0);
         applyStimulus(1, 10, 0);
      join
      fork
         applyStimulus(0, 25, 3);
         applyStimulus(1, 25, 3);
      join
      repeat (4) @(posedge clk);
      #1;
      monEn = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2cs_reg_arbiter.md
# i2cs_reg_arbiter

Shares the I2C-slave peripheral's single register-file access port between two requesters: the APB-side register interface (port 0) and the I2C-bus-side protocol engine (port 1). Each requester issues one read or write at a time with a req/ack handshake. The block arbitrates round-robin, sequences one register strobe per transaction, captures read data and returns it with the ack. It sits between the APB slave interface, the I2C slave FSM and the register module.

## Interface
- ADDR_W, 12, register address width
- DATA_W, 32, register data width
- apb_pclk_i  in  1  clock; all logic on rising edge
- apb_presetn_i  in  1  reset, asynchronous assert, active-low
- apb_req_i  in  1  port 0 request; held with we/addr/wdata stable until apb_ack_o
- apb_we_i  in  1  port 0: 1 = write, 0 = read
- apb_addr_i  in  ADDR_W  port 0 address
- apb_wdata_i  in  DATA_W  port 0 write data
- apb_ack_o  out  1  port 0 one-cycle completion pulse
- apb_rdata_o  out  DATA_W  port 0 read data, valid with apb_ack_o, held until next port 0 read ack
- i2c_req_i, i2c_we_i, i2c_addr_i, i2c_wdata_i, i2c_ack_o, i2c_rdata_o: port 1, identical semantics
- reg_addr_o  out  ADDR_W  address to register module
- reg_wdata_o  out  DATA_W  write data to register module
- reg_we_o  out  1  one-cycle write strobe
- reg_re_o  out  1  one-cycle read strobe (read-side-effect, e.g. FIFO pop)
- reg_rdata_i  in  DATA_W  combinational read data for reg_addr_o
- reg_owner_o  out  1  port owning the current/last transaction
- busy_o  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP. Reset: IDLE.
- IDLE: if any req high, pick winner, latch its we/addr/wdata into reg_*_o and owner, go ACCESS; else stay.
- ACCESS (exactly 1 cycle): reg_we_o = we, reg_re_o = !we; at cycle end capture reg_rdata_i into owner's rdata register if read; go RESP.
- RESP (exactly 1 cycle): owner's ack_o = 1. Owner's req is masked this cycle; if the other port's req is high, latch it and go straight to ACCESS, else go IDLE.
- Arbitration: single requester wins outright. Both high: grant the port not granted last (last_grant register, reset = 1, so port 0 wins the first tie). last_grant updates on every grant.
- Writes never update rdata registers; rdata of the non-owner port never changes.
- No address decode or error response; every request completes.

## Timing
- Request seen in IDLE at cycle N: strobe at N+1, ack (and rdata) at N+2.
- Back-to-back alternating ports: one transaction per 2 cycles (ACCESS/RESP pairs).
- Same port issuing again: req must be high in the cycle after its ack; sampled in IDLE, minimum 3-cycle spacing.
- reg_addr_o/reg_wdata_o/reg_owner_o are registered and hold after the transaction until the next grant.
- Simultaneous reqs in IDLE: one granted; loser stays pending and is granted from RESP without passing IDLE.
- Reset (any state, including mid-ACCESS/RESP): all outputs 0 immediately (strobes, acks, busy, addr, wdata, rdata, owner); state IDLE; last_grant = 1; the in-flight transaction is dropped with no ack. The requester re-issues after reset release.

## Structure
- Package i2cs_arb_pkg: state enum (IDLE, ACCESS, RESP), port index constants PORT_APB = 0, PORT_I2C = 1.
- Sub-module rr_arb2: 2-request round-robin picker (req[1:0], mask, last_grant in; gnt index, valid out; combinational). FSM, latches and rdata registers stay in i2cs_reg_arbiter.

## Test plan
- Reset with both reqs low -> all outputs 0, busy_o = 0; release, hold 5 cycles idle -> no strobes.
- Port 0 write addr 0x004, data 0xDEADBEEF at N -> reg_we_o at N+1 with those values, apb_ack_o at N+2, apb_rdata_o unchanged, no i2c_ack_o.
- Port 1 read addr 0x010, reg model returns 0x000000A5 -> reg_re_o at N+1, i2c_ack_o at N+2 with i2c_rdata_o = 0xA5, apb_rdata_o unchanged.
- Both ports request reads continuously from reset -> grants alternate 0,1,0,1, ack every 2 cycles, first to port 0, no starvation over 20 transactions.
- Port 0 request, apb_presetn_i asserted during ACCESS -> reg_re_o drops immediately, no apb_ack_o; re-request after release completes in 2 cycles with port 0 winning a simultaneous tie.
- Port 0 read immediately followed by port 1 write pending -> ACCESS(0), RESP(0 ack), ACCESS(1) with no IDLE cycle, i2c_ack_o 2 cycles after apb_ack_o.
